// File: rtl/mem_ctrl_port_if.sv
// Fetch and load/store handshake bundle between the ICache/LSB requesters and mem_ctrl_port.
// Requesters use the master modport; the memory controller uses slave.
interface mem_ctrl_port_if #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned IF_BYTES = 4
);
  logic                    ICache_need_update_instr;
  logic [ADDR_W-1:0]       instr_address;
  logic                    instr_valid;
  logic [8*IF_BYTES-1:0]   instr;

  logic                    lsb_req;
  logic                    lsb_wr;
  logic [ADDR_W-1:0]       lsb_addr;
  logic [1:0]              lsb_size;
  logic [31:0]             lsb_wdata;
  logic                    lsb_done;
  logic [31:0]             lsb_rdata;

  modport master (
    output ICache_need_update_instr, instr_address,
    output lsb_req, lsb_wr, lsb_addr, lsb_size, lsb_wdata,
    input  instr_valid, instr, lsb_done, lsb_rdata
  );

  modport slave (
    input  ICache_need_update_instr, instr_address,
    input  lsb_req, lsb_wr, lsb_addr, lsb_size, lsb_wdata,
    output instr_valid, instr, lsb_done, lsb_rdata
  );
endinterface

// File: rtl/mem_ctrl_port.sv
// Byte-serial sequencer between ICache/LSB and a single-port synchronous RAM.
// Reads capture byte k two edges after its address is issued; writes emit one byte per edge.
module mem_ctrl_port #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned IF_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              jump_wrong,
  mem_ctrl_port_if.slave    bus
);

  typedef enum logic [1:0] {StIdle, StIfRd, StLsRd, StLsWr} state_e;

  localparam logic [2:0] FetchBytes = 3'(IF_BYTES);

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     base_q, base_d;
  logic [ADDR_W-1:0]     mem_a_q, mem_a_d;
  logic [2:0]            len_q, len_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           data_q, data_d;
  logic [8*IF_BYTES-1:0] instr_q, instr_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [7:0]            dout_q, dout_d;
  logic                  wr_q, wr_d;
  logic                  ivalid_q, ivalid_d;
  logic                  done_q, done_d;

  logic [2:0]            lsb_len;
  logic [1:0]            cap_idx;
  logic [ADDR_W-1:0]     next_a;

  assign next_a  = base_q + ADDR_W'(cnt_q);
  assign cap_idx = 2'(cnt_q - 3'd2);

  always_comb begin
    lsb_len = 3'd4;
    unique case (bus.lsb_size)
      2'd0:    lsb_len = 3'd1;
      2'd1:    lsb_len = 3'd2;
      default: lsb_len = 3'd4;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    wdata_d  = wdata_q;
    data_d   = data_q;
    mem_a_d  = mem_a_q;
    dout_d   = dout_q;
    wr_d     = wr_q;
    instr_d  = instr_q;
    rdata_d  = rdata_q;
    ivalid_d = 1'b0;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        // A pulse cycle blocks acceptance so level-held requests are not served twice.
        if (!ivalid_q && !done_q) begin
          if (bus.lsb_req) begin
            base_d  = bus.lsb_addr;
            len_d   = lsb_len;
            cnt_d   = 3'd1;
            data_d  = '0;
            wdata_d = bus.lsb_wdata;
            mem_a_d = bus.lsb_addr;
            if (bus.lsb_wr) begin
              state_d = StLsWr;
              dout_d  = bus.lsb_wdata[7:0];
              wr_d    = 1'b1;
            end else begin
              state_d = StLsRd;
            end
          end else if (bus.ICache_need_update_instr && !jump_wrong) begin
            base_d  = bus.instr_address;
            len_d   = FetchBytes;
            cnt_d   = 3'd1;
            data_d  = '0;
            mem_a_d = bus.instr_address;
            state_d = StIfRd;
          end
        end
      end

      StIfRd, StLsRd: begin
        if (cnt_q < len_q) mem_a_d = next_a;
        if (cnt_q >= 3'd2) data_d[{cap_idx, 3'b000} +: 8] = mem_din;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == len_q + 3'd1) begin
          state_d = StIdle;
          cnt_d   = '0;
          if (state_q == StIfRd) begin
            instr_d  = data_d[8*IF_BYTES-1:0];
            ivalid_d = 1'b1;
          end else begin
            rdata_d = data_d;
            done_d  = 1'b1;
          end
        end
        // Flush kills a fetch outright, including a pulse being raised on this edge.
        if (state_q == StIfRd && jump_wrong) begin
          state_d  = StIdle;
          cnt_d    = '0;
          instr_d  = instr_q;
          ivalid_d = 1'b0;
        end
      end

      StLsWr: begin
        if (cnt_q < len_q) begin
          mem_a_d = next_a;
          dout_d  = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
          wr_d    = 1'b1;
          cnt_d   = cnt_q + 3'd1;
        end else begin
          wr_d    = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      base_q   <= '0;
      mem_a_q  <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      wdata_q  <= '0;
      data_q   <= '0;
      instr_q  <= '0;
      rdata_q  <= '0;
      dout_q   <= '0;
      wr_q     <= 1'b0;
      ivalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else if (rdy) begin
      state_q  <= state_d;
      base_q   <= base_d;
      mem_a_q  <= mem_a_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      wdata_q  <= wdata_d;
      data_q   <= data_d;
      instr_q  <= instr_d;
      rdata_q  <= rdata_d;
      dout_q   <= dout_d;
      wr_q     <= wr_d;
      ivalid_q <= ivalid_d;
      done_q   <= done_d;
    end
  end

  // Gating with rdy keeps a frozen write cycle from hitting the RAM repeatedly.
  assign mem_wr          = wr_q & rdy;
  assign mem_a           = mem_a_q;
  assign mem_dout        = dout_q;
  assign bus.instr_valid = ivalid_q;
  assign bus.instr       = instr_q;
  assign bus.lsb_done    = done_q;
  assign bus.lsb_rdata   = rdata_q;

endmodule

// File: doc/mem_ctrl_port.md
Name: mem_ctrl_port

Overview:
- Memory-side responder for the instruction cache's fetch handshake, plus a load/store port for the LSB.
- Sequences byte-wide accesses to the single-port synchronous RAM.
- For a fetch: returns a little-endian 32-bit word with a one-cycle valid pulse.
- Sits between the ICache/LSB and the top-level RAM pins; it is the only driver of the RAM address and write strobe.

Parameters:
- ADDR_W, 32, width of all byte addresses
- IF_BYTES, 4, bytes assembled per instruction fetch

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global ready; low freezes all state
- mem_din  in  8  RAM read byte, valid the cycle after RAM samples mem_a
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM byte address
- mem_wr  out  1  RAM write strobe (1 = write)
- ICache_need_update_instr  in  1  fetch request, level-held by requester
- instr_address  in  32  fetch address, word-aligned
- instr_valid  out  1  one-cycle pulse: instr holds the fetched word
- instr  out  32  fetched word
- jump_wrong  in  1  misprediction flush
- lsb_req  in  1  load/store request, level-held until lsb_done
- lsb_wr  in  1  1 = store, 0 = load
- lsb_addr  in  32  load/store byte address
- lsb_size  in  2  access size: 0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes; 3 is treated as 4 bytes
- lsb_wdata  in  32  store data; the low bytes are used
- lsb_done  out  1  one-cycle completion pulse
- lsb_rdata  out  32  load data, zero-extended; sign extension is done by the LSB

Behaviour:
- Reset, synchronous, active-high: state=IDLE.
  - mem_a=0, mem_dout=0, mem_wr=0.
  - instr_valid=0, instr=0, lsb_done=0, lsb_rdata=0.
  - Byte counters cleared.
  - Reset during any access abandons it with no pulse.
- rdy=0: every register holds its value. mem_wr is driven as (internal write flag AND rdy), so no byte is written twice.
- States: IDLE, IF_RD, LS_RD, LS_WR.
- IDLE, at edge E0:
  - lsb_req=1 wins over ICache_need_update_instr.
  - On a load/store: latch addr, size and wdata; go to LS_WR if lsb_wr, else LS_RD.
  - Else, on a fetch request: latch instr_address and go to IF_RD.
  - The address latch covers the first byte: mem_a<=base at E0.
- Read timing, for n bytes:
  - mem_a <= base+k at edge E(k), for k = 0..n-1.
  - Byte k is captured from mem_din at edge E(k+2).
  - Byte k goes to bits [8k+7:8k] (little-endian).
- IF_RD, n=4:
  - At E5, instr <= assembled word and instr_valid<=1, with state back to IDLE.
  - instr_valid drops at E6.
  - Latency: request sampled at E0, valid high in the cycle after E5.
  - No new request is accepted in the edge where instr_valid is high.
- LS_RD: same timing with n from lsb_size.
  - lsb_done and lsb_rdata are set at edge E(n+1); upper bytes are 0.
  - 1-byte load completes at E2; 4-byte load at E5.
- LS_WR:
  - At E(k): mem_a<=base+k, mem_dout<=wdata[8k+7:8k], internal write flag=1, for k = 0..n-1.
  - At E(n): write flag<=0, lsb_done<=1, state back to IDLE.
- Outside writes, mem_wr=0.
- mem_a addition wraps modulo 2^32.
- jump_wrong=1 at any edge:
  - If in IF_RD: abort, state=IDLE, instr_valid forced 0 (including a pulse that would be set this edge).
  - If in IDLE: suppress acceptance of a fetch this edge.
  - Load/store transactions are never aborted by jump_wrong; a store always completes.
- An in-flight fetch is never preempted by lsb_req; the LSB waits until IDLE.
- Requests asserted in the same edge a pulse is issued are not seen until the next edge in IDLE.

Test Plan:
- Fetch: RAM[0x100..0x103] = 13,05,10,00, request address 0x100. Required:
  - mem_a = 0x100, 0x101, 0x102, 0x103 on consecutive cycles.
  - instr_valid pulses exactly one cycle with instr = 0x00100513, 5 cycles after acceptance.
- Store word 0xDEADBEEF to 0x2000 with lsb_size=2. Required:
  - Bytes EF, BE, AD, DE are written to 0x2000..0x2003 with mem_wr high for exactly 4 cycles.
  - lsb_done pulses at E4.
  - A subsequent 2-byte load from 0x2002 returns lsb_rdata = 0x0000DEAD at E3.
- Simultaneous lsb_req (1-byte load at 0x30 = 0x7F) and fetch request in IDLE. Required:
  - The load is served first (lsb_rdata = 0x7F).
  - The fetch is served afterwards.
  - There is never more than one pulse per cycle.
- jump_wrong asserted two cycles into a fetch. Required:
  - No instr_valid pulse.
  - State is IDLE next cycle.
  - A new fetch to 0x200 completes normally.
  - jump_wrong during a store still yields all bytes written and lsb_done.
- rdy held low for 3 cycles in the middle of a store. Required:
  - mem_wr=0 and mem_a is held during the stall.
  - Each byte is written exactly once.
  - The completion cycle shifts by 3.
- rst pulsed in the middle of a fetch. Required:
  - Next cycle all outputs are 0, with no instr_valid.
  - The next request is accepted normally.
